// File: rtl/fixed_point_dot_product_pkg.sv
// Shared types and default sizing for the sign-magnitude dot-product engine.
package fixed_point_dot_product_pkg;

  localparam int DEF_BITSIZE = 16;
  localparam int DEF_FRAC    = 11;
  localparam int DEF_GUARD   = 8;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FLUSH  = 2'd1,
    RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/fixed_point_dot_product_if.sv
// Term input stream and result output stream of the dot-product engine.
interface fixed_point_dot_product_if
  import fixed_point_dot_product_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE
) ();

  logic               in_valid;
  logic               in_ready;
  logic [BITSIZE-1:0] in_a;
  logic [BITSIZE-1:0] in_b;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [BITSIZE-1:0] out_data;
  logic               out_sat;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/fixed_point_multiply.sv
// Combinational sign-magnitude fixed-point multiply; the product is truncated
// to FRAC fraction bits and its magnitude saturated to the word range.
module fixed_point_multiply
  import fixed_point_dot_product_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE,
  parameter int FRAC    = DEF_FRAC
) (
  input  logic [BITSIZE-1:0] a_i,
  input  logic [BITSIZE-1:0] b_i,
  output logic [BITSIZE-1:0] p_o
);

  localparam int MW = BITSIZE - 1;
  localparam int PW = 2 * MW;

  logic [PW-1:0] full;
  logic [PW-1:0] shifted;
  logic          ovf;
  logic [MW-1:0] mag;

  always_comb begin
    full    = PW'(a_i[MW-1:0]) * PW'(b_i[MW-1:0]);
    shifted = full >> FRAC;
    ovf     = |shifted[PW-1:MW];
    mag     = ovf ? {MW{1'b1}} : shifted[MW-1:0];
  end

  assign p_o = {a_i[BITSIZE-1] ^ b_i[BITSIZE-1], mag};

endmodule

// File: rtl/fixed_point_dot_product.sv
// Streaming sign-magnitude dot product: registered product stage feeding a
// saturating two's-complement accumulator, result held until consumed.
module fixed_point_dot_product
  import fixed_point_dot_product_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE,
  parameter int FRAC    = DEF_FRAC,
  parameter int GUARD   = DEF_GUARD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fixed_point_dot_product_if.slave  bus
);

  localparam int ACC_W = BITSIZE + GUARD;
  localparam int MW    = BITSIZE - 1;
  localparam logic signed [ACC_W:0] LIM_HI = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] LIM_LO = -LIM_HI;

  state_e state_q, state_d;

  logic [BITSIZE-1:0]      mul_p;
  logic [BITSIZE-1:0]      prod_q;
  logic                    prod_valid_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    acc_sat_q, acc_sat_d;

  logic                    accept;
  logic                    handshake;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] prod_tc;
  logic signed [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0]        acc_abs;
  logic                    clip;

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == RESULT);
  assign accept        = bus.in_valid && bus.in_ready;
  assign handshake     = bus.out_valid && bus.out_ready;

  fixed_point_multiply #(
    .BITSIZE (BITSIZE),
    .FRAC    (FRAC)
  ) u_mul (
    .a_i (bus.in_a),
    .b_i (bus.in_b),
    .p_o (mul_p)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (accept && bus.in_last) state_d = FLUSH;
      FLUSH:   state_d = RESULT;
      RESULT:  if (bus.out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Magnitude zero maps to zero whatever its sign bit, so 0x8000 adds nothing.
  always_comb begin
    prod_ext  = {{(ACC_W-MW){1'b0}}, prod_q[MW-1:0]};
    prod_tc   = prod_q[BITSIZE-1] ? -prod_ext : prod_ext;
    sum_wide  = {acc_q[ACC_W-1], acc_q} + {prod_tc[ACC_W-1], prod_tc};
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    if (prod_valid_q) begin
      if (sum_wide > LIM_HI) begin
        acc_d     = LIM_HI[ACC_W-1:0];
        acc_sat_d = 1'b1;
      end else if (sum_wide < LIM_LO) begin
        acc_d     = LIM_LO[ACC_W-1:0];
        acc_sat_d = 1'b1;
      end else begin
        acc_d     = sum_wide[ACC_W-1:0];
      end
    end
    if (handshake) begin
      acc_d     = '0;
      acc_sat_d = 1'b0;
    end
  end

  // The accumulator never holds -2^(ACC_W-1), so its negation always fits.
  always_comb begin
    acc_abs = acc_q[ACC_W-1] ? ACC_W'(-acc_q) : ACC_W'(acc_q);
    clip    = |acc_abs[ACC_W-1:MW];
  end

  assign bus.out_data = {acc_q[ACC_W-1], clip ? {MW{1'b1}} : acc_abs[MW-1:0]};
  assign bus.out_sat  = clip | acc_sat_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      acc_q        <= '0;
      acc_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prod_valid_q <= accept;
      if (accept) prod_q <= mul_p;
      acc_q        <= acc_d;
      acc_sat_q    <= acc_sat_d;
    end
  end

endmodule
